// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - time-multiplexed common-anode 7-segment digit scanner
module seg_scan_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000,
    parameter int LZ_BLANK   = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      load,
    input  logic [NUM_DIGITS*4-1:0]   value_in,
    output logic [3:0]                digit_data,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_done
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_W-1:0]          div_cnt;
    logic [IDX_W-1:0]          idx;
    logic [NUM_DIGITS*4-1:0]   shown;
    logic [NUM_DIGITS*4-1:0]   pending;
    logic                      pend_valid;

    logic                      tick;
    logic                      wrap;
    logic [IDX_W-1:0]          idx_n;
    logic [NUM_DIGITS*4-1:0]   shown_nx;
    logic [NUM_DIGITS-1:0]     blank_mask;
    logic [NUM_DIGITS-1:0]     an_nx;
    logic                      upper_zero;

    // Scan step, frame transfer and leading-zero mask, all evaluated on the
    // value that will be on display after this cycle's transfer (if any).
    always_comb begin
        tick       = en && (div_cnt == DIV_LAST);
        idx_n      = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        wrap       = tick && (idx_n == '0);
        shown_nx   = (wrap && pend_valid) ? pending : shown;
        upper_zero = 1'b1;
        blank_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero    = upper_zero && (shown_nx[i*4 +: 4] == 4'h0);
            blank_mask[i] = upper_zero && (i != 0) && (LZ_BLANK != 0);
        end
        an_nx = blank_mask[idx_n] ? '1 : ~(NUM_DIGITS'(1) << idx_n);
    end

    // Prescaler, digit index and registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            idx        <= '0;
            shown      <= '0;
            digit_data <= 4'h0;
            an         <= '1;
            frame_done <= 1'b0;
        end else if (!en) begin
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            div_cnt    <= tick ? '0 : div_cnt + DIV_W'(1);
            frame_done <= wrap;
            if (tick) begin
                idx        <= idx_n;
                shown      <= shown_nx;
                digit_data <= shown_nx[idx_n*4 +: 4];
                an         <= an_nx;
            end
        end
    end

    // Pending value: a load always wins over the transfer clearing pend_valid,
    // so a value loaded on a wrap tick survives to the following frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= '0;
            pend_valid <= 1'b0;
        end else if (load) begin
            pending    <= value_in;
            pend_valid <= 1'b1;
        end else if (wrap) begin
            pend_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - directed self-checking bench for seg_scan_mux
module tb_seg_scan_mux;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] value_in;
    logic [3:0]  digit_data;
    logic [3:0]  an;
    logic        frame_done;
    logic [3:0]  nb_digit_data;
    logic [3:0]  nb_an;
    logic        nb_frame_done;

    int tests_run;
    int tests_failed;

    seg_scan_mux #(.NUM_DIGITS(4), .CLK_DIV(4), .LZ_BLANK(1)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .value_in   (value_in),
        .digit_data (digit_data),
        .an         (an),
        .frame_done (frame_done)
    );

    seg_scan_mux #(.NUM_DIGITS(4), .CLK_DIV(4), .LZ_BLANK(0)) u_dut_nb (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .value_in   (value_in),
        .digit_data (nb_digit_data),
        .an         (nb_an),
        .frame_done (nb_frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_disp(input string tag, input logic [3:0] exp_an,
                            input logic [3:0] exp_dd, input logic exp_fd);
        check({tag, "_an"}, 32'(an), 32'(exp_an));
        check({tag, "_dd"}, 32'(digit_data), 32'(exp_dd));
        check({tag, "_fd"}, 32'(frame_done), 32'(exp_fd));
    endtask

    task automatic do_load(input logic [15:0] v);
        load     = 1'b1;
        value_in = v;
        clk_n(1);
        load     = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        load     = 1'b0;
        value_in = 16'h0;

        clk_n(3);
        chk_disp("reset", 4'b1111, 4'h0, 1'b0);
        rst_n = 1'b1;
        en    = 1'b1;

        // Test 1: load 1234 at cycle 2; first frame dark (shown=0), then 4,3,2,1
        clk_n(1);
        do_load(16'h1234);                               // after e2
        clk_n(2);  chk_disp("t1_e4",  4'b1111, 4'h0, 1'b0);
        clk_n(12); chk_disp("t1_e16", 4'b1110, 4'h4, 1'b1);
        clk_n(1);  check("t1_fd_pulse", 32'(frame_done), 32'd0);
        clk_n(3);  chk_disp("t1_e20", 4'b1101, 4'h3, 1'b0);
        clk_n(4);  chk_disp("t1_e24", 4'b1011, 4'h2, 1'b0);
        clk_n(4);  chk_disp("t1_e28", 4'b0111, 4'h1, 1'b0);
        clk_n(4);  chk_disp("t1_e32", 4'b1110, 4'h4, 1'b1);

        // Test 2: 00A0 blanks digits 3 and 2
        do_load(16'h00A0);                               // after e33
        clk_n(15); chk_disp("t2_e48", 4'b1110, 4'h0, 1'b1);
        clk_n(4);  chk_disp("t2_e52", 4'b1101, 4'hA, 1'b0);
        clk_n(4);  chk_disp("t2_e56", 4'b1111, 4'h0, 1'b0);
        clk_n(4);  chk_disp("t2_e60", 4'b1111, 4'h0, 1'b0);
        clk_n(4);  chk_disp("t2_e64", 4'b1110, 4'h0, 1'b1);

        // Test 3: 5555 then BEEF in one frame, only BEEF is ever shown
        do_load(16'h5555);
        do_load(16'hBEEF);                               // after e66
        clk_n(2);  chk_disp("t3_e68", 4'b1101, 4'hA, 1'b0);
        clk_n(12); chk_disp("t3_e80", 4'b1110, 4'hF, 1'b1);
        clk_n(4);  chk_disp("t3_e84", 4'b1101, 4'hE, 1'b0);
        clk_n(4);  chk_disp("t3_e88", 4'b1011, 4'hE, 1'b0);
        clk_n(4);  chk_disp("t3_e92", 4'b0111, 4'hB, 1'b0);
        clk_n(4);  chk_disp("t3_e96", 4'b1110, 4'hF, 1'b1);

        // Test 4: 1111 pending, 2222 loaded on the wrap tick itself
        do_load(16'h1111);                               // after e97
        clk_n(14);                                       // after e111
        do_load(16'h2222);                               // load seen at e112
        chk_disp("t4_e112", 4'b1110, 4'h1, 1'b1);
        clk_n(4);  chk_disp("t4_e116", 4'b1101, 4'h1, 1'b0);
        clk_n(12); chk_disp("t4_e128", 4'b1110, 4'h2, 1'b1);
        clk_n(4);  chk_disp("t4_e132", 4'b1101, 4'h2, 1'b0);

        // Test 5: en low for 10 cycles mid-frame, div_cnt=1 idx=1 held
        clk_n(1);                                        // after e133
        en = 1'b0;
        clk_n(1);  chk_disp("t5_off1",  4'b1111, 4'h2, 1'b0);
        clk_n(9);  chk_disp("t5_off10", 4'b1111, 4'h2, 1'b0);
        en = 1'b1;
        clk_n(2);  chk_disp("t5_resume_dark", 4'b1111, 4'h2, 1'b0);
        clk_n(1);  chk_disp("t5_idx2", 4'b1011, 4'h2, 1'b0);
        clk_n(4);  chk_disp("t5_idx3", 4'b0111, 4'h2, 1'b0);
        clk_n(4);  chk_disp("t5_wrap", 4'b1110, 4'h2, 1'b1);

        // Test 6: async reset with pend_valid=1 drops the pending value
        do_load(16'h3333);
        rst_n = 1'b0;
        #1;
        chk_disp("t6_async", 4'b1111, 4'h0, 1'b0);
        check("t6_nb_async_an", 32'(nb_an), 32'hF);
        clk_n(1);
        rst_n = 1'b1;
        clk_n(4);  chk_disp("t6_r4", 4'b1111, 4'h0, 1'b0);
        check("t6_nb_r4_an", 32'(nb_an), 32'b1101);
        check("t6_nb_r4_dd", 32'(nb_digit_data), 32'h0);
        clk_n(4);  check("t6_nb_r8_an", 32'(nb_an), 32'b1011);
        clk_n(4);  check("t6_nb_r12_an", 32'(nb_an), 32'b0111);
        clk_n(4);  chk_disp("t6_r16", 4'b1110, 4'h0, 1'b1);
        check("t6_nb_r16_an", 32'(nb_an), 32'b1110);
        check("t6_nb_r16_dd", 32'(nb_digit_data), 32'h0);
        check("t6_nb_r16_fd", 32'(nb_frame_done), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
